// File: rtl/gb_write_arbiter_pkg.sv
// Shared types and constants for the global-buffer write arbiter.
// Requester ids, FSM encoding and default buffer geometry.
package gb_pkg;

    localparam int REQ_EXT = 0;
    localparam int REQ_SYS = 1;
    localparam int REQ_AGG = 2;

    localparam int GB_ADDR_WIDTH = 16;
    localparam int GB_DATA_WIDTH = 128;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

endpackage

// File: rtl/gb_write_arbiter_if.sv
// Requester beat bus plus global-buffer write port.
// master = requesters/buffer side, slave = arbiter.
interface gb_write_arbiter_if
    import gb_pkg::*;
#(
    parameter int N_REQ      = 3,
    parameter int ADDR_WIDTH = GB_ADDR_WIDTH,
    parameter int DATA_WIDTH = GB_DATA_WIDTH,
    parameter int ID_WIDTH   = 2
);

    logic [N_REQ-1:0]            req_valid;
    logic [N_REQ-1:0]            req_last;
    logic [N_REQ*ADDR_WIDTH-1:0] req_addr;
    logic [N_REQ*DATA_WIDTH-1:0] req_data;
    logic [N_REQ-1:0]            req_ready;
    logic                        gb_write;
    logic [ADDR_WIDTH-1:0]       gb_waddr;
    logic [DATA_WIDTH-1:0]       gb_din;
    logic [ID_WIDTH-1:0]         grant_id;
    logic                        busy;

    modport master (
        output req_valid, req_last, req_addr, req_data,
        input  req_ready, gb_write, gb_waddr, gb_din,
        input  grant_id, busy
    );

    modport slave (
        input  req_valid, req_last, req_addr, req_data,
        output req_ready, gb_write, gb_waddr, gb_din,
        output grant_id, busy
    );

endinterface

// File: rtl/gb_write_arbiter_rr_select.sv
// Combinational round-robin pick: first valid index
// scanning ptr, ptr+1, ... with explicit wrap to zero.
module rr_select #(
    parameter int N_REQ    = 3,
    parameter int ID_WIDTH = 2
) (
    input  logic [N_REQ-1:0]    valid,
    input  logic [ID_WIDTH-1:0] ptr,
    output logic [ID_WIDTH-1:0] idx,
    output logic                any_valid
);

    logic found;
    int   c;

    always_comb begin
        idx       = '0;
        any_valid = |valid;
        found     = 1'b0;
        c         = (int'(ptr) >= N_REQ) ? 0 : int'(ptr);
        for (int i = 0; i < N_REQ; i++) begin
            if (!found && valid[c]) begin
                idx   = ID_WIDTH'(c);
                found = 1'b1;
            end
            c = (c == N_REQ - 1) ? 0 : c + 1;
        end
    end

endmodule

// File: rtl/gb_write_arbiter.sv
// Global-buffer write arbiter: round-robin burst grants over
// valid/ready beats with a one-cycle registered write stage.
module gb_write_arbiter
    import gb_pkg::*;
#(
    parameter int ADDR_WIDTH = GB_ADDR_WIDTH,
    parameter int DATA_WIDTH = GB_DATA_WIDTH,
    parameter int N_REQ      = 3,
    parameter int MAX_BURST  = 16,
    parameter int ID_WIDTH   = 2
) (
    input  logic clk,
    input  logic rstn,
    gb_write_arbiter_if.slave bus
);

    localparam int CNT_W = $clog2(MAX_BURST) + 1;

    state_t               state, state_nx;
    logic [ID_WIDTH-1:0]  owner, owner_nx;
    logic [ID_WIDTH-1:0]  rr_ptr, rr_ptr_nx;
    logic [ID_WIDTH-1:0]  pick;
    logic [CNT_W-1:0]     beat_cnt, beat_cnt_nx;
    logic                 any_valid;
    logic                 accept;
    logic                 rel;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_data;
    logic                  wr_q;
    logic [ADDR_WIDTH-1:0] waddr_q;
    logic [DATA_WIDTH-1:0] din_q;

    rr_select #(
        .N_REQ    (N_REQ),
        .ID_WIDTH (ID_WIDTH)
    ) u_rr (
        .valid     (bus.req_valid),
        .ptr       (rr_ptr),
        .idx       (pick),
        .any_valid (any_valid)
    );

    assign sel_addr = bus.req_addr[int'(owner)*ADDR_WIDTH +: ADDR_WIDTH];
    assign sel_data = bus.req_data[int'(owner)*DATA_WIDTH +: DATA_WIDTH];

    assign accept = (state == GRANT) && bus.req_valid[owner];
    // last beat and the burst cap can coincide; either one releases once
    assign rel = accept &&
                 (bus.req_last[owner] ||
                  (beat_cnt == CNT_W'(MAX_BURST - 1)));

    always_comb begin
        bus.req_ready = '0;
        for (int i = 0; i < N_REQ; i++) begin
            bus.req_ready[i] = (state == GRANT) &&
                               (owner == ID_WIDTH'(i));
        end
    end

    always_comb begin
        state_nx    = state;
        owner_nx    = owner;
        rr_ptr_nx   = rr_ptr;
        beat_cnt_nx = beat_cnt;
        unique case (state)
            IDLE: begin
                if (any_valid) begin
                    owner_nx    = pick;
                    beat_cnt_nx = '0;
                    state_nx    = GRANT;
                end
            end
            GRANT: begin
                if (accept) begin
                    beat_cnt_nx = beat_cnt + 1'b1;
                end
                if (rel) begin
                    state_nx  = IDLE;
                    rr_ptr_nx = (owner == ID_WIDTH'(N_REQ - 1)) ?
                                '0 : owner + 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= IDLE;
            owner    <= '0;
            rr_ptr   <= '0;
            beat_cnt <= '0;
        end else begin
            state    <= state_nx;
            owner    <= owner_nx;
            rr_ptr   <= rr_ptr_nx;
            beat_cnt <= beat_cnt_nx;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_q    <= 1'b0;
            waddr_q <= '0;
            din_q   <= '0;
        end else begin
            wr_q <= accept;
            if (accept) begin
                waddr_q <= sel_addr;
                din_q   <= sel_data;
            end
        end
    end

    assign bus.gb_write = wr_q;
    assign bus.gb_waddr = waddr_q;
    assign bus.gb_din   = din_q;
    assign bus.grant_id = owner;
    assign bus.busy     = (state == GRANT);

endmodule

// File: tb/tb_gb_write_arbiter.sv
// Directed bench for gb_write_arbiter: behavioural requesters
// drive beats; write log and grant order checked against tables.
module tb_gb_write_arbiter;

    localparam int AW = 16;
    localparam int DW = 128;
    localparam int NR = 3;

    logic clk  = 1'b0;
    logic rstn = 1'b1;

    always #5 clk = ~clk;

    gb_write_arbiter_if #(
        .N_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(2)
    ) bus ();

    gb_write_arbiter #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .N_REQ(NR),
        .MAX_BURST(16), .ID_WIDTH(2)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    int errors = 0;
    int checks = 0;

    int          en    [NR];
    int          hold  [NR];
    int          pos   [NR];
    int          total [NR];
    int          blen  [NR];
    logic [15:0] base  [NR];

    logic [15:0]  wa_q[$];
    logic [127:0] wd_q[$];
    logic [1:0]   gr_q[$];
    logic         prev_busy;
    logic [15:0]  exp_a[$];
    logic [1:0]   exp_g[$];

    task automatic chk(string tag, logic [127:0] obs, logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        logic [15:0] a;
        for (int i = 0; i < NR; i++) begin
            a = base[i] + 16'(pos[i]);
            bus.req_valid[i] = (en[i] != 0) && (hold[i] == 0) &&
                               (pos[i] < total[i]);
            bus.req_last[i]  = ((pos[i] + 1) % blen[i]) == 0;
            bus.req_addr[i*AW +: AW] = a;
            bus.req_data[i*DW +: DW] = {8{a}};
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < NR; i++) begin
            en[i] = 0; hold[i] = 0; pos[i] = 0;
            total[i] = 0; blen[i] = 1; base[i] = '0;
        end
        wa_q.delete(); wd_q.delete(); gr_q.delete();
        prev_busy = 1'b0;
    endtask

    task automatic cyc();
        logic [NR-1:0] acc;
        acc = bus.req_valid & bus.req_ready;
        @(posedge clk);
        #1;
        for (int i = 0; i < NR; i++) if (acc[i]) pos[i]++;
        if (bus.gb_write) begin
            wa_q.push_back(bus.gb_waddr);
            wd_q.push_back(bus.gb_din);
        end
        if (bus.busy && !prev_busy) gr_q.push_back(bus.grant_id);
        prev_busy = bus.busy;
        drive();
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        clear_model();
        drive();
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
    endtask

    task automatic cmp_log(string tag, input logic [15:0] ea[$],
                           input logic [1:0] eg[$]);
        chk({tag, "_nwr"}, 128'(wa_q.size()), 128'(ea.size()));
        for (int i = 0; i < ea.size(); i++) begin
            if (i < wa_q.size()) begin
                chk({tag, "_addr"}, 128'(wa_q[i]), 128'(ea[i]));
                chk({tag, "_data"}, wd_q[i], {8{ea[i]}});
            end
        end
        chk({tag, "_ngr"}, 128'(gr_q.size()), 128'(eg.size()));
        for (int i = 0; i < eg.size(); i++) begin
            if (i < gr_q.size())
                chk({tag, "_grant"}, 128'(gr_q[i]), 128'(eg[i]));
        end
    endtask

    initial begin
        logic [11:0] t2_busy;
        logic [11:0] t2_wr;

        // reset state
        #1 rstn = 1'b0;
        clear_model();
        drive();
        #12;
        chk("rst_write", 128'(bus.gb_write), 128'(0));
        chk("rst_busy", 128'(bus.busy), 128'(0));
        chk("rst_ready", 128'(bus.req_ready), 128'(0));
        chk("rst_gid", 128'(bus.grant_id), 128'(0));
        chk("rst_waddr", 128'(bus.gb_waddr), 128'(0));
        chk("rst_din", bus.gb_din, 128'(0));

        // requester 1 alone, 4-beat burst
        do_reset();
        en[1] = 1; total[1] = 4; blen[1] = 4; base[1] = 16'h0100;
        drive();
        cyc();
        chk("t1_busy", 128'(bus.busy), 128'(1));
        chk("t1_gid", 128'(bus.grant_id), 128'(1));
        chk("t1_ready", 128'(bus.req_ready), 128'(3'b010));
        chk("t1_nowr", 128'(bus.gb_write), 128'(0));
        for (int b = 0; b < 4; b++) begin
            cyc();
            chk("t1_wr", 128'(bus.gb_write), 128'(1));
            chk("t1_waddr", 128'(bus.gb_waddr), 128'(16'h0100 + b));
            chk("t1_din", bus.gb_din, {8{16'(16'h0100 + b)}});
        end
        chk("t1_rel", 128'(bus.busy), 128'(0));
        cyc();
        chk("t1_idle_wr", 128'(bus.gb_write), 128'(0));
        chk("t1_idle_busy", 128'(bus.busy), 128'(0));
        chk("t1_rrptr", 128'(dut.rr_ptr), 128'(2));

        // all three valid, 2-beat bursts
        do_reset();
        for (int i = 0; i < NR; i++) begin
            en[i] = 1; total[i] = 100; blen[i] = 2;
            base[i] = 16'((i + 1) << 12);
        end
        drive();
        t2_busy = 12'b011011011011;
        t2_wr   = 12'b110110110110;
        for (int k = 0; k < 12; k++) begin
            cyc();
            chk("t2_busy", 128'(bus.busy), 128'(t2_busy[k]));
            chk("t2_wr", 128'(bus.gb_write), 128'(t2_wr[k]));
        end
        exp_a = '{16'h1000, 16'h1001, 16'h2000, 16'h2001,
                  16'h3000, 16'h3001, 16'h1002, 16'h1003};
        exp_g = '{2'd0, 2'd1, 2'd2, 2'd0};
        cmp_log("t2", exp_a, exp_g);

        // 20-beat burst split at 16, requester 0 slips in
        do_reset();
        en[2] = 1; total[2] = 20; blen[2] = 20; base[2] = 16'h3000;
        total[0] = 2; blen[0] = 2; base[0] = 16'h1000;
        drive();
        for (int k = 1; k <= 30; k++) begin
            if (k == 4) begin
                en[0] = 1;
                drive();
            end
            cyc();
            if (k == 17) chk("t3_split_idle", 128'(bus.busy), 128'(0));
        end
        exp_a.delete();
        for (int i = 0; i < 16; i++) exp_a.push_back(16'h3000 + 16'(i));
        exp_a.push_back(16'h1000);
        exp_a.push_back(16'h1001);
        for (int i = 16; i < 20; i++) exp_a.push_back(16'h3000 + 16'(i));
        exp_g = '{2'd2, 2'd0, 2'd2};
        cmp_log("t3", exp_a, exp_g);

        // owner stalls mid-burst, grant is held
        do_reset();
        en[0] = 1; total[0] = 4; blen[0] = 4; base[0] = 16'h1000;
        en[1] = 1; total[1] = 2; blen[1] = 2; base[1] = 16'h2000;
        drive();
        repeat (3) cyc();
        hold[0] = 1;
        drive();
        for (int k = 0; k < 5; k++) begin
            cyc();
            chk("t4_busy", 128'(bus.busy), 128'(1));
            chk("t4_gid", 128'(bus.grant_id), 128'(0));
            chk("t4_ready", 128'(bus.req_ready), 128'(3'b001));
            chk("t4_wr", 128'(bus.gb_write), 128'(0));
        end
        hold[0] = 0;
        drive();
        repeat (8) cyc();
        exp_a = '{16'h1000, 16'h1001, 16'h1002, 16'h1003,
                  16'h2000, 16'h2001};
        exp_g = '{2'd0, 2'd1};
        cmp_log("t4", exp_a, exp_g);

        // async reset with a write pending
        do_reset();
        en[2] = 1; total[2] = 10; blen[2] = 10; base[2] = 16'h3000;
        drive();
        cyc();
        cyc();
        chk("t5_pending", 128'(bus.gb_write), 128'(1));
        #2 rstn = 1'b0;
        #1;
        chk("t5_rst_wr", 128'(bus.gb_write), 128'(0));
        chk("t5_rst_busy", 128'(bus.busy), 128'(0));
        chk("t5_rst_ready", 128'(bus.req_ready), 128'(0));
        chk("t5_rst_waddr", 128'(bus.gb_waddr), 128'(0));
        en[1] = 1; total[1] = 2; blen[1] = 2; base[1] = 16'h2000;
        drive();
        @(posedge clk);
        #3 rstn = 1'b1;
        prev_busy = 1'b0;
        wa_q.delete(); wd_q.delete(); gr_q.delete();
        cyc();
        chk("t5_busy", 128'(bus.busy), 128'(1));
        chk("t5_gid", 128'(bus.grant_id), 128'(1));
        chk("t5_nowr", 128'(bus.gb_write), 128'(0));

        // last coincides with beat 16
        do_reset();
        en[0] = 1; total[0] = 18; blen[0] = 16; base[0] = 16'h1000;
        en[1] = 1; total[1] = 2; blen[1] = 2; base[1] = 16'h2000;
        drive();
        for (int k = 1; k <= 25; k++) begin
            cyc();
            if (k == 17) begin
                chk("t6_idle", 128'(bus.busy), 128'(0));
                chk("t6_rrptr", 128'(dut.rr_ptr), 128'(1));
            end
        end
        exp_a.delete();
        for (int i = 0; i < 16; i++) exp_a.push_back(16'h1000 + 16'(i));
        exp_a.push_back(16'h2000);
        exp_a.push_back(16'h2001);
        exp_a.push_back(16'h1010);
        exp_a.push_back(16'h1011);
        exp_g = '{2'd0, 2'd1, 2'd0};
        cmp_log("t6", exp_a, exp_g);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/gb_write_arbiter.md
Name: gb_write_arbiter

Overview:
Arbitrates the single global-buffer write port between three requesters: external loader (0), systolic writeback (1) and aggregation writeback (2). Replaces static priority muxing with valid/ready handshakes, round-robin burst grants and a registered write stage. Sits directly in front of the global buffer write port (waddr/din/write). Sequencing controllers keep their address generation and only present beats.

Parameters:
ADDR_WIDTH, 16, global buffer address width
DATA_WIDTH, 128, global buffer line width (8 bits x 16 lanes)
N_REQ, 3, number of requesters
MAX_BURST, 16, max beats per grant before forced release
ID_WIDTH, 2, grant id width; must be >= max(1, clog2(N_REQ))

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
req_valid  in  N_REQ  per-requester beat valid
req_last  in  N_REQ  marks final beat of requester burst
req_addr  in  N_REQ*ADDR_WIDTH  packed write addresses, requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
req_data  in  N_REQ*DATA_WIDTH  packed write data, same packing
req_ready  out  N_REQ  per-requester beat accept
gb_write  out  1  global buffer write enable
gb_waddr  out  ADDR_WIDTH  global buffer write address
gb_din  out  DATA_WIDTH  global buffer write data
grant_id  out  ID_WIDTH  current owner, valid while busy=1
busy  out  1  high in GRANT state

Behaviour:
- Single clock clk; asynchronous active-low reset rstn.
- Reset values: state=IDLE, rr_ptr=0, beat_cnt=0, owner=0. Outputs: gb_write=0, gb_waddr=0, gb_din=0, grant_id=0, busy=0, req_ready=0.
- Beat accept: req_valid[i] & req_ready[i] in the same cycle.
- req_ready[i] is combinational: (state==GRANT) & (owner==i). It never depends on req_valid. All other requesters see ready=0.
- IDLE:
  - If any req_valid, select the first valid index scanning rr_ptr, rr_ptr+1, ... mod N_REQ.
  - Load owner with that index, clear beat_cnt, go to GRANT. No beat is accepted in the IDLE cycle.
  - If no req_valid, stay in IDLE.
- GRANT:
  - On each accepted beat, register req_addr/req_data of the owner into gb_waddr/gb_din and set gb_write=1 next cycle. Latency is exactly 1 cycle from accept to write.
  - gb_write=0 in any cycle following a non-accept. gb_waddr/gb_din hold their last values when gb_write=0.
  - beat_cnt increments per accepted beat. Its width is clog2(MAX_BURST)+1 bits, so it never wraps.
  - Release when an accepted beat has req_last=1, or when it is beat number MAX_BURST (beat_cnt==MAX_BURST-1 at accept).
  - On release: rr_ptr <= (owner+1) mod N_REQ, state <= IDLE. There is always exactly one IDLE bubble cycle between grants.
  - If the owner deasserts valid mid-burst, the grant is held indefinitely. There is no timeout; the other requesters wait.
- Simultaneous events:
  - All requesters valid in IDLE → round-robin order from rr_ptr.
  - req_last together with the MAX_BURST condition → a single release.
- Forced release (MAX_BURST without last): the requester re-arbitrates later and continues its burst under a new grant. Requesters must tolerate this split.
- grant_id = owner; busy = (state==GRANT).
- Reset mid-burst: everything returns to reset values immediately. A pending registered write is dropped (gb_write forced 0).
- N_REQ index wrap: use explicit compare-and-zero, not power-of-two masking, because N_REQ=3.

Decomposition:
- Shared package gb_pkg holds:
  - requester id constants REQ_EXT=0, REQ_SYS=1, REQ_AGG=2;
  - state encoding IDLE=1'b0, GRANT=1'b1;
  - default ADDR_WIDTH and DATA_WIDTH.
- One natural sub-module: rr_select. It is a combinational N_REQ-way round-robin priority pick taking the valid vector and rr_ptr, and returning the index plus an any_valid flag.
- The FSM, beat counter and output register remain in gb_write_arbiter.

Test Plan:
- Requester 1 alone, 4 beats addr 0x0100..0x0103, last on beat 4 → gb_write high 4 cycles, starting 1 cycle after each accept. Addrs in order; then 1 IDLE cycle; rr_ptr=2.
- All 3 valid continuously, 2-beat bursts, from reset → grant order 0,1,2,0, each grant separated by exactly one busy=0 cycle.
- Requester 2 with 20 beats, no last until beat 20 → release after beat 16. Requester 0 (valid) is granted next. Requester 2 is regranted later for beats 17..20 with no lost or duplicated address.
- Owner 0 drops valid for 5 cycles mid-burst while requester 1 is valid → busy stays 1, grant_id=0, req_ready[1]=0, gb_write=0 during the gap. The burst then resumes.
- Assert rstn=0 asynchronously one cycle after an accept → gb_write=0 immediately and the pending write is not issued. After reset, the first grant goes to the lowest valid index starting at 0.
- req_last on beat 16 exactly (MAX_BURST coincidence) → single release, rr_ptr advances once, next grant normal.
